// File: rtl/vid_timing_monitor.sv
// vid_timing_monitor: passive raster timing checker for the video output bus.
// Measures line/frame geometry from sync and blank strobes, publishes one
// coherent measurement set per frame, tracks lock and flags timing errors.
module vid_timing_monitor #(
  parameter int C_H_WIDTH         = 10,
  parameter int C_V_WIDTH         = 9,
  parameter bit C_SYNC_ACTIVE_LOW = 1'b1,
  parameter int C_LOCK_FRAMES     = 2
) (
  input  logic                 pixel_clk,
  input  logic                 rst_n,
  input  logic                 hsync,
  input  logic                 hblank,
  input  logic                 vsync,
  input  logic                 vblank,
  output logic [C_H_WIDTH-1:0] h_total,
  output logic [C_H_WIDTH-1:0] h_active,
  output logic [C_H_WIDTH-1:0] h_sync_width,
  output logic [C_V_WIDTH-1:0] v_total,
  output logic [C_V_WIDTH-1:0] v_active,
  output logic [C_V_WIDTH-1:0] v_sync_width,
  output logic                 frame_valid,
  output logic                 locked,
  output logic                 timing_error,
  output logic [15:0]          frame_count
);

  localparam logic [C_H_WIDTH-1:0] H_MAX       = {C_H_WIDTH{1'b1}};
  localparam logic [C_H_WIDTH-1:0] H_MAX_M1    = H_MAX - 1'b1;
  localparam logic [C_V_WIDTH-1:0] V_MAX       = {C_V_WIDTH{1'b1}};
  localparam logic [3:0]           LOCK_TARGET = 4'(C_LOCK_FRAMES);
  localparam logic [3:0]           LOCK_MIN    = 4'(C_LOCK_FRAMES - 1);

  function automatic logic [C_H_WIDTH-1:0] h_inc(input logic [C_H_WIDTH-1:0] x);
    return (x == H_MAX) ? x : x + 1'b1;
  endfunction

  function automatic logic [C_V_WIDTH-1:0] v_inc(input logic [C_V_WIDTH-1:0] x);
    return (x == V_MAX) ? x : x + 1'b1;
  endfunction

  // normalised syncs (1 = active) and leading-edge strobes
  logic hs, vs, hs_d, vs_d, hs_edge, vs_edge;
  assign hs      = hsync ^ C_SYNC_ACTIVE_LOW;
  assign vs      = vsync ^ C_SYNC_ACTIVE_LOW;
  assign hs_edge = hs & ~hs_d;
  assign vs_edge = vs & ~vs_d;

  // horizontal measurement state
  logic [C_H_WIDTH-1:0] h_cnt, hs_cnt, ha_cnt;
  logic [C_H_WIDTH-1:0] line_tot, line_act, line_sync;
  logic [C_H_WIDTH-1:0] ref_tot;
  logic                 ref_valid;

  // vertical / frame state
  logic [C_V_WIDTH-1:0] v_cnt, va_cnt, vs_cnt;
  logic [C_V_WIDTH-1:0] v_cnt_next, va_cnt_next, vs_cnt_next;
  logic                 v_sat, line_bad, bad_next, frame_bad, first_frame, h_lost;

  // snapshot taken at the vsync edge, published one clock later
  logic                 commit_pend, snap_bad;
  logic [C_H_WIDTH-1:0] snap_tot, snap_act, snap_sync;
  logic [C_V_WIDTH-1:0] snap_vt, snap_va, snap_vs;

  // lock tracking
  logic [3:0] match_cnt, match_next;
  logic       prev_valid, set_match, lock_next;

  // a line is bad if its length differs from the frame's first line or any counter pinned
  assign line_bad = hs_edge & ((ref_valid & (h_cnt != ref_tot)) | (h_cnt == H_MAX) |
                               (hs_cnt == H_MAX) | (ha_cnt == H_MAX));
  assign bad_next = frame_bad | line_bad | v_sat;
  // fires once, on the clock where the line counter reaches all-ones
  assign h_lost   = ~hs_edge & (h_cnt == H_MAX_M1);

  // register the normalised syncs for edge detection
  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      hs_d <= 1'b0;
      vs_d <= 1'b0;
    end else begin
      hs_d <= hs;
      vs_d <= vs;
    end
  end

  // per-line counters; values of the finished line latched on each hsync edge
  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      h_cnt     <= '0;
      hs_cnt    <= '0;
      ha_cnt    <= '0;
      line_tot  <= '0;
      line_act  <= '0;
      line_sync <= '0;
    end else if (hs_edge) begin
      line_tot  <= h_cnt;
      line_act  <= ha_cnt;
      line_sync <= hs_cnt;
      h_cnt     <= {{(C_H_WIDTH-1){1'b0}}, 1'b1};
      hs_cnt    <= {{(C_H_WIDTH-1){1'b0}}, hs};
      ha_cnt    <= {{(C_H_WIDTH-1){1'b0}}, ~hblank};
    end else begin
      h_cnt <= h_inc(h_cnt);
      if (hs)      hs_cnt <= h_inc(hs_cnt);
      if (!hblank) ha_cnt <= h_inc(ha_cnt);
    end
  end

  // line-counted vertical increments; a coincident hsync edge still counts here
  always_comb begin
    v_cnt_next  = v_cnt;
    va_cnt_next = va_cnt;
    vs_cnt_next = vs_cnt;
    v_sat       = 1'b0;
    if (hs_edge) begin
      v_cnt_next = v_inc(v_cnt);
      v_sat      = (v_cnt == V_MAX);
      if (!vblank) begin
        va_cnt_next = v_inc(va_cnt);
        v_sat       = v_sat | (va_cnt == V_MAX);
      end
      if (vs) begin
        vs_cnt_next = v_inc(vs_cnt);
        v_sat       = v_sat | (vs_cnt == V_MAX);
      end
    end
  end

  // vertical counters, frame reference and snapshot on the vsync edge
  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      v_cnt       <= '0;
      va_cnt      <= '0;
      vs_cnt      <= '0;
      frame_bad   <= 1'b0;
      ref_valid   <= 1'b0;
      ref_tot     <= '0;
      first_frame <= 1'b1;
      commit_pend <= 1'b0;
      snap_bad    <= 1'b0;
      snap_tot    <= '0;
      snap_act    <= '0;
      snap_sync   <= '0;
      snap_vt     <= '0;
      snap_va     <= '0;
      snap_vs     <= '0;
    end else begin
      commit_pend <= 1'b0;
      if (vs_edge) begin
        v_cnt     <= '0;
        va_cnt    <= '0;
        vs_cnt    <= '0;
        frame_bad <= 1'b0;
        ref_valid <= 1'b0;
        if (first_frame) begin
          first_frame <= 1'b0;
        end else begin
          commit_pend <= 1'b1;
          snap_tot    <= hs_edge ? h_cnt  : line_tot;
          snap_act    <= hs_edge ? ha_cnt : line_act;
          snap_sync   <= hs_edge ? hs_cnt : line_sync;
          snap_vt     <= v_cnt_next;
          snap_va     <= va_cnt_next;
          snap_vs     <= vs_cnt_next;
          snap_bad    <= bad_next;
        end
      end else begin
        v_cnt     <= v_cnt_next;
        va_cnt    <= va_cnt_next;
        vs_cnt    <= vs_cnt_next;
        frame_bad <= bad_next;
        if (hs_edge && !ref_valid) begin
          ref_tot   <= h_cnt;
          ref_valid <= 1'b1;
        end
      end
      if (h_lost) first_frame <= 1'b1;
    end
  end

  // compare the pending set against the last published one
  always_comb begin
    set_match = prev_valid && !snap_bad &&
                (snap_tot == h_total) && (snap_act == h_active) && (snap_sync == h_sync_width) &&
                (snap_vt == v_total) && (snap_va == v_active) && (snap_vs == v_sync_width);
    match_next = 4'd0;
    if (set_match) match_next = (match_cnt >= LOCK_TARGET) ? LOCK_TARGET : match_cnt + 4'd1;
    lock_next = set_match && (match_next >= LOCK_MIN);
  end

  // publish measurements, maintain lock, report errors
  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      h_total      <= '0;
      h_active     <= '0;
      h_sync_width <= '0;
      v_total      <= '0;
      v_active     <= '0;
      v_sync_width <= '0;
      frame_valid  <= 1'b0;
      locked       <= 1'b0;
      timing_error <= 1'b0;
      frame_count  <= '0;
      match_cnt    <= '0;
      prev_valid   <= 1'b0;
    end else begin
      frame_valid  <= 1'b0;
      timing_error <= 1'b0;
      if (commit_pend) begin
        h_total      <= snap_tot;
        h_active     <= snap_act;
        h_sync_width <= snap_sync;
        v_total      <= snap_vt;
        v_active     <= snap_va;
        v_sync_width <= snap_vs;
        frame_valid  <= 1'b1;
        frame_count  <= frame_count + 16'd1;
        match_cnt    <= match_next;
        locked       <= lock_next;
        timing_error <= locked & ~set_match;
        prev_valid   <= 1'b1;
      end
      // hsync vanished: drop lock and forget the reference set
      if (h_lost) begin
        locked     <= 1'b0;
        match_cnt  <= '0;
        prev_valid <= 1'b0;
        if (locked) timing_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vid_timing_monitor.sv
// tb_vid_timing_monitor: scoreboard bench for vid_timing_monitor. Two
// instances run side by side: dut 0 with active-low syncs, dut 1 with
// active-high syncs fed the inverted strobes; both must publish the same sets.
// Raster is a small 48x24 geometry (same shape as the nominal mode) so the
// run stays short; loss of sync still uses the full 10-bit line counter.
module tb_vid_timing_monitor;

  localparam int H_TOT   = 48;  // clocks per line
  localparam int H_ACT   = 36;  // hblank-low clocks per line
  localparam int H_SW    = 4;   // hsync clocks per line
  localparam int V_TOT   = 24;  // lines per frame
  localparam int V_ACT   = 16;  // vblank-low lines
  localparam int VS_W    = 3;   // vsync lines
  localparam int VS_LINE = 19;  // first line whose hsync edge sees vsync
  localparam int SH_MID  = 24;  // vsync leads the line start by half a line
  localparam int SH_COIN = 0;   // vsync edge on the hsync edge

  typedef struct packed {
    logic [9:0]  ht, ha, hsw;
    logic [8:0]  vt, va, vsw;
    logic        lk, te;
    logic [15:0] fc;
  } rec_t;

  logic pixel_clk = 1'b0;
  logic rst_n = 1'b0;
  logic hs_a = 1'b0, vs_a = 1'b0, hblank = 1'b1, vblank = 1'b1;
  logic hsync_lo, vsync_lo;
  assign hsync_lo = ~hs_a;
  assign vsync_lo = ~vs_a;

  logic [9:0]  ht_o [2], ha_o [2], hsw_o [2];
  logic [8:0]  vt_o [2], va_o [2], vsw_o [2];
  logic        fv_o [2], lk_o [2], te_o [2];
  logic [15:0] fc_o [2];

  int   n_cmp = 0, n_fail = 0, exp_fc = 0;
  int   stray_te [2] = '{0, 0};
  rec_t exp_q[$];
  rec_t e_rec, g_rec;

  always #5 pixel_clk = ~pixel_clk;

  vid_timing_monitor #(.C_SYNC_ACTIVE_LOW(1'b1)) dut_lo (
    .pixel_clk(pixel_clk), .rst_n(rst_n), .hsync(hsync_lo), .hblank(hblank),
    .vsync(vsync_lo), .vblank(vblank),
    .h_total(ht_o[0]), .h_active(ha_o[0]), .h_sync_width(hsw_o[0]),
    .v_total(vt_o[0]), .v_active(va_o[0]), .v_sync_width(vsw_o[0]),
    .frame_valid(fv_o[0]), .locked(lk_o[0]), .timing_error(te_o[0]), .frame_count(fc_o[0]));

  vid_timing_monitor #(.C_SYNC_ACTIVE_LOW(1'b0)) dut_hi (
    .pixel_clk(pixel_clk), .rst_n(rst_n), .hsync(hs_a), .hblank(hblank),
    .vsync(vs_a), .vblank(vblank),
    .h_total(ht_o[1]), .h_active(ha_o[1]), .h_sync_width(hsw_o[1]),
    .v_total(vt_o[1]), .v_active(va_o[1]), .v_sync_width(vsw_o[1]),
    .frame_valid(fv_o[1]), .locked(lk_o[1]), .timing_error(te_o[1]), .frame_count(fc_o[1]));

  function automatic rec_t got(input int d);
    return {ht_o[d], ha_o[d], hsw_o[d], vt_o[d], va_o[d], vsw_o[d], lk_o[d], te_o[d], fc_o[d]};
  endfunction

  // scoreboard: every published set must match the next expected commit
  always @(negedge pixel_clk) begin
    if (fv_o[0] || fv_o[1]) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_commit: frame_valid=%0b/%0b fc=%0d/%0d, want no commit",
                 fv_o[0], fv_o[1], fc_o[0], fc_o[1]);
      end else begin
        e_rec = exp_q.pop_front();
        for (int d = 0; d < 2; d++) begin
          g_rec = got(d);
          if (d == 1) n_cmp++;
          if (fv_o[d] !== 1'b1 || g_rec !== e_rec) begin
            n_fail++;
            $display("FAIL commit_dut%0d: got fv=%0b ht=%0d ha=%0d hs=%0d vt=%0d va=%0d vs=%0d lk=%0b te=%0b fc=%0d want fv=1 ht=%0d ha=%0d hs=%0d vt=%0d va=%0d vs=%0d lk=%0b te=%0b fc=%0d",
                     d, fv_o[d], g_rec.ht, g_rec.ha, g_rec.hsw, g_rec.vt, g_rec.va, g_rec.vsw,
                     g_rec.lk, g_rec.te, g_rec.fc, e_rec.ht, e_rec.ha, e_rec.hsw, e_rec.vt,
                     e_rec.va, e_rec.vsw, e_rec.lk, e_rec.te, e_rec.fc);
          end else begin
            $display("commit dut%0d fc=%0d ht=%0d ha=%0d vt=%0d lk=%0b te=%0b", d,
                     g_rec.fc, g_rec.ht, g_rec.ha, g_rec.vt, g_rec.lk, g_rec.te);
          end
        end
      end
    end
    for (int d = 0; d < 2; d++) if (te_o[d] && !fv_o[d]) stray_te[d]++;
  end

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic set_idle();
    hs_a = 1'b0; vs_a = 1'b0; hblank = 1'b1; vblank = 1'b1;
  endtask

  task automatic expect_commit(input int ht, input int ha, input bit lk, input bit te);
    rec_t r;
    exp_fc++;
    r.ht = 10'(ht); r.ha = 10'(ha); r.hsw = 10'(H_SW);
    r.vt = 9'(V_TOT); r.va = 9'(V_ACT); r.vsw = 9'(VS_W);
    r.lk = lk; r.te = te; r.fc = 16'(exp_fc);
    exp_q.push_back(r);
  endtask

  task automatic drive_line(input int line, input int len, input int shift);
    int p, s;
    s = VS_LINE * H_TOT - shift;
    for (int c = 0; c < len; c++) begin
      p      = line * H_TOT + c;
      hs_a   = (c < H_SW);
      vs_a   = (p >= s) && (p < s + VS_W * H_TOT);
      hblank = (c < H_TOT - H_ACT);
      vblank = (line >= V_ACT);
      tick();
    end
  endtask

  task automatic drive_frame(input int shift, input int glitch_line);
    for (int l = 0; l < V_TOT; l++)
      drive_line(l, (l == glitch_line) ? H_TOT - 1 : H_TOT, shift);
  endtask

  task automatic apply_reset();
    set_idle();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    exp_fc = 0;
  endtask

  task automatic test_reset();
    set_idle();
    rst_n = 1'b0;
    tick();
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (got(d) !== '0 || fv_o[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_dut%0d: got outputs=%h fv=%0b, want all zero", d, got(d), fv_o[d]);
      end else $display("reset dut%0d outputs zero", d);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    exp_fc = 0;
  endtask

  task automatic test_nominal();
    drive_frame(SH_MID, -1);                       // first vsync only arms
    expect_commit(H_TOT, H_ACT, 1'b0, 1'b0); drive_frame(SH_MID, -1);
    expect_commit(H_TOT, H_ACT, 1'b1, 1'b0); drive_frame(SH_MID, -1);
    expect_commit(H_TOT, H_ACT, 1'b1, 1'b0); drive_frame(SH_MID, -1);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL nominal_drain: %0d commits outstanding, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_glitch();
    // short line is the last one latched before the vsync edge
    expect_commit(H_TOT - 1, H_ACT - 1, 1'b0, 1'b1); drive_frame(SH_MID, VS_LINE - 2);
    expect_commit(H_TOT, H_ACT, 1'b0, 1'b0); drive_frame(SH_MID, -1);
    expect_commit(H_TOT, H_ACT, 1'b1, 1'b0); drive_frame(SH_MID, -1);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL glitch_drain: %0d commits outstanding, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_loss_of_sync();
    int te_cnt [2];
    int te_at [2];
    te_cnt = '{0, 0};
    te_at  = '{0, 0};
    set_idle();
    for (int t = 1; t <= 1100; t++) begin
      tick();
      for (int d = 0; d < 2; d++) if (te_o[d]) begin te_cnt[d]++; te_at[d] = t; end
    end
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (te_cnt[d] != 1 || te_at[d] > 1023) begin
        n_fail++;
        $display("FAIL loss_error_dut%0d: got %0d pulses (last at clock %0d), want 1 by clock 1023",
                 d, te_cnt[d], te_at[d]);
      end else $display("loss dut%0d timing_error at clock %0d", d, te_at[d]);
      n_cmp++;
      if (lk_o[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL loss_locked_dut%0d: got %0b, want 0", d, lk_o[d]);
      end
    end
    drive_frame(SH_MID, -1);                       // partial frame discarded
    expect_commit(H_TOT, H_ACT, 1'b0, 1'b0); drive_frame(SH_MID, -1);
    expect_commit(H_TOT, H_ACT, 1'b1, 1'b0); drive_frame(SH_MID, -1);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL loss_drain: %0d commits outstanding, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid_frame();
    for (int l = 0; l < 10; l++) drive_line(l, H_TOT, SH_MID);
    rst_n = 1'b0;
    tick();
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (got(d) !== '0 || fv_o[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL midreset_dut%0d: got outputs=%h fv=%0b, want all zero", d, got(d), fv_o[d]);
      end else $display("mid-frame reset dut%0d outputs zero", d);
    end
    tick(); tick();
    rst_n = 1'b1;
    exp_fc = 0;
    for (int l = 10; l < V_TOT; l++) drive_line(l, H_TOT, SH_MID);  // vsync here: no commit
    expect_commit(H_TOT, H_ACT, 1'b0, 1'b0); drive_frame(SH_MID, -1);
    expect_commit(H_TOT, H_ACT, 1'b1, 1'b0); drive_frame(SH_MID, -1);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL midreset_drain: %0d commits outstanding, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_coincident();
    apply_reset();
    drive_frame(SH_COIN, -1);
    expect_commit(H_TOT, H_ACT, 1'b0, 1'b0); drive_frame(SH_COIN, -1);
    expect_commit(H_TOT, H_ACT, 1'b1, 1'b0); drive_frame(SH_COIN, -1);
    expect_commit(H_TOT, H_ACT, 1'b1, 1'b0); drive_frame(SH_COIN, -1);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL coincident_drain: %0d commits outstanding, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_glitch();
    test_loss_of_sync();
    test_reset_mid_frame();
    test_coincident();
    // the only error pulse outside a commit is the loss-of-sync one
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (stray_te[d] != 1) begin
        n_fail++;
        $display("FAIL stray_error_dut%0d: got %0d pulses outside commits, want 1", d, stray_te[d]);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vid_timing_monitor.md
Name: vid_timing_monitor

Overview:
- Passive checker on the system86 video output bus, sitting directly downstream beside the pixel logger in simulation and synthesizable for on-board debug.
- Measures raw timing from the sync and blank outputs: line length, active width, sync widths, lines per frame, active lines.
- Publishes one coherent measurement set per frame and asserts a lock flag once timing is stable across consecutive frames.
- Flags timing errors after lock.

Parameters:
C_H_WIDTH, 10, width of horizontal counters (clocks per line).
C_V_WIDTH, 9, width of vertical counters (lines per frame).
C_SYNC_ACTIVE_LOW, 1, 1 = hsync/vsync active low; 0 = active high. Blanks are always active high.
C_LOCK_FRAMES, 2, consecutive identical frames required to assert locked (1..15).

Ports:
pixel_clk  in  1  pixel clock (vid_clk); all logic on rising edge
rst_n  in  1  synchronous reset, active low
hsync  in  1  horizontal sync
hblank  in  1  horizontal blank
vsync  in  1  vertical sync
vblank  in  1  vertical blank
h_total  out  C_H_WIDTH  clocks per line
h_active  out  C_H_WIDTH  non-hblank clocks per line
h_sync_width  out  C_H_WIDTH  clocks with hsync active per line
v_total  out  C_V_WIDTH  lines per frame
v_active  out  C_V_WIDTH  lines started with vblank low
v_sync_width  out  C_V_WIDTH  lines started with vsync active
frame_valid  out  1  one-cycle pulse; measurement outputs just updated
locked  out  1  timing stable
timing_error  out  1  one-cycle pulse on mismatch while locked
frame_count  out  16  committed frames, wraps at 0xFFFF->0

Behaviour:
- Reset (rst_n low at a clock edge):
  - All outputs 0; all counters 0; edge registers cleared.
  - first_frame flag set.
  - Reset mid-frame discards all partial measurements.
- Sync normalisation and edge detection:
  - Internal hs/vs = input XOR C_SYNC_ACTIVE_LOW, so active = 1.
  - Inputs are registered once (hs_d, vs_d).
  - Leading edge = hs & ~hs_d (same rule for vs).
- Horizontal counters:
  - On an hs leading edge: h_cnt <= 1; else h_cnt <= h_cnt+1, saturating at all-ones.
  - hs_cnt and ha_cnt count cycles with hs=1 and hblank=0 respectively; both reload on the edge (to hs / ~hblank of the edge cycle) and saturate.
  - On each hs leading edge, the line values line_tot=h_cnt, line_act=ha_cnt, line_sync=hs_cnt are latched.
  - The first line of each frame sets the frame reference. Any later line in the same frame whose line_tot differs, or any saturated counter, sets frame_bad.
- Vertical counters:
  - Counted in hs leading edges: v_cnt++, va_cnt++ if vblank=0, vs_cnt++ if vs=1. All saturate; saturation sets frame_bad.
  - A vs leading edge and an hs leading edge in the same cycle: the hs edge is counted into the frame that is closing, then the counters restart at 0.
- Commit on vs leading edge:
  - If first_frame: discard the partial frame, clear first_frame, no pulse, outputs unchanged.
  - Otherwise, on the next clock:
    - Load outputs from the last latched line values and the vertical counters.
    - Pulse frame_valid for 1 cycle; frame_count++.
    - Compare the new set against the previous committed set. Equal and not frame_bad: match_cnt++, saturating at C_LOCK_FRAMES. Else: match_cnt <= 0.
    - locked <= (match_cnt_next >= C_LOCK_FRAMES-1). The comparison set counts as the first frame, so lock occurs on the C_LOCK_FRAMES-th identical commit.
    - If locked was 1 and the frame mismatches: pulse timing_error in the same cycle as frame_valid, and clear locked.
  - Vertical counters restart and frame_bad clears at the edge.
- Loss of sync:
  - If h_cnt saturates (no hsync for 2^C_H_WIDTH-1 clocks): clear locked and match_cnt immediately, set first_frame.
  - Pulse timing_error if locked was 1.
- The block never drives the video path. Output latency is 1 clock after the vs leading edge is detected, i.e. 2 clocks after the raw vsync transition.

Test Plan:
- Nominal timing: h_total 384, hblank low 288 clocks, hsync 32, 264 lines, vblank low 224 lines, vsync 8 lines, active-low sync. First frame produces no frame_valid. Second frame gives outputs 384/288/32/264/224/8 and frame_count=1. locked rises with the 2nd committed frame (frame_count=2).
- Polarity: C_SYNC_ACTIVE_LOW=0 with inverted stimulus -> identical results to the nominal scenario.
- Single-line glitch: after lock, one line of 383 clocks -> that frame's commit gives timing_error pulse, locked=0. Two clean frames later locked=1 again.
- Loss of sync: hsync held inactive 1100 clocks while locked -> locked=0 and one timing_error pulse by clock 1023. Recovery requires one discarded partial frame plus 2 committed frames.
- Reset mid-frame: rst_n low 3 clocks at line 100 -> all outputs 0 and frame_count=0 the clock after reset asserts. The first vsync after release produces no frame_valid.
- Coincident edges: vsync and hsync leading edges on the same clock -> v_total still 264, no off-by-one.
